// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath widths and block-controller state encoding
package aes_pkg;
  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    START     = 3'd2,
    WAIT_CORE = 3'd3,
    WRITE     = 3'd4,
    ERROR     = 3'd5
  } ctrl_state_t;
endpackage

// File: rtl/flex_timer.sv
// flex_timer: up-counter with sync clear, enable and a terminal-count flag at MAX
module flex_timer #(
  parameter int W   = 16,
  parameter int MAX = 63
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear dominates enable so a restart never sees a stale count
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  // count register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign tc_o = cnt_q == W'(MAX);
endmodule

// File: rtl/aes_blk_ctrl.sv
// aes_blk_ctrl: sequences one AES block from input FIFO through the core into the output FIFO
module aes_blk_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             key_ready,
  input  logic             mode_in,
  input  logic             in_fifo_full,
  input  logic             in_fifo_empty,
  input  logic             aes_done,
  input  logic             out_fifo_empty,
  input  logic             clear_err,
  output logic             in_read_en,
  output logic             aes_start,
  output logic             aes_mode,
  output logic             out_write_en,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_count
);
  ctrl_state_t      state_q, state_d;
  logic             tmo;
  logic             wr_fire;
  logic             rd_q, start_q, mode_q, wr_q, busy_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  // 16 bits covers the largest legal timeout; the counter is cleared in START
  flex_timer #(.W(16), .MAX(TIMEOUT_CYCLES - 1)) u_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clr_i (state_q == START),
    .en_i  (state_q == WAIT_CORE),
    .tc_o  (tmo)
  );

  assign wr_fire = state_q == WRITE && out_fifo_empty;

  // next-state: done beats timeout, unused encodings recover to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = in_fifo_full && key_ready ? FETCH : IDLE;
      FETCH:     state_d = in_fifo_empty ? START : FETCH;
      START:     state_d = WAIT_CORE;
      WAIT_CORE: state_d = aes_done ? WRITE : tmo ? ERROR : WAIT_CORE;
      WRITE:     state_d = out_fifo_empty ? IDLE : WRITE;
      ERROR:     state_d = clear_err ? IDLE : ERROR;
      default:   state_d = IDLE;
    endcase
  end

  // state plus outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      start_q <= 1'b0;
      mode_q  <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= state_d == FETCH;
      start_q <= state_d == START;
      wr_q    <= wr_fire;
      busy_q  <= state_d inside {FETCH, START, WAIT_CORE, WRITE};
      err_q   <= state_d == ERROR;
      if (state_q == IDLE && state_d == FETCH) mode_q <= mode_in;
      if (wr_fire) cnt_q <= cnt_q + CNT_W'(1);
    end

  assign in_read_en   = rd_q;
  assign aes_start    = start_q;
  assign aes_mode     = mode_q;
  assign out_write_en = wr_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign blk_count    = cnt_q;
endmodule

// File: tb/tb_aes_blk_ctrl.sv
// tb_aes_blk_ctrl: directed and random block transfers against a transaction-level model
module tb_aes_blk_ctrl;
  localparam int T  = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic key_ready = 1'b0, mode_in = 1'b0, in_fifo_full = 1'b0, in_fifo_empty = 1'b1;
  logic aes_done = 1'b0, out_fifo_empty = 1'b1, clear_err = 1'b0;
  logic in_read_en, aes_start, aes_mode, out_write_en, busy, err;
  logic [CW-1:0] blk_count;

  int checks = 0, errors = 0;
  int cyc_n = 0, fifo_words = 0, drop_left = 0, done_at = -1000, w_out = 0, lat_cur = 100;
  int n_rd, n_start, n_wr, t_start, t_wr, t_err;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  aes_blk_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .key_ready      (key_ready),
    .mode_in        (mode_in),
    .in_fifo_full   (in_fifo_full),
    .in_fifo_empty  (in_fifo_empty),
    .aes_done       (aes_done),
    .out_fifo_empty (out_fifo_empty),
    .clear_err      (clear_err),
    .in_read_en     (in_read_en),
    .aes_start      (aes_start),
    .aes_mode       (aes_mode),
    .out_write_en   (out_write_en),
    .busy           (busy),
    .err            (err),
    .blk_count      (blk_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one cycle: observe strobes at negedge, then update FIFO/core/out-FIFO models after the edge
  task automatic tick();
    @(negedge clk);
    if (in_read_en) n_rd++;
    if (aes_start) begin
      n_start++;
      t_start = cyc_n;
      if (lat_cur <= T) done_at = cyc_n + lat_cur;
    end
    if (out_write_en) begin n_wr++; t_wr = cyc_n; end
    if (err && t_err < 0) t_err = cyc_n;
    if (in_read_en) begin
      if (drop_left > 0) drop_left--;
      else fifo_words = 0;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    in_fifo_full   = fifo_words == 4;
    in_fifo_empty  = fifo_words == 0;
    aes_done       = cyc_n == done_at;
    out_fifo_empty = !(cyc_n > done_at && cyc_n <= done_at + w_out);
  endtask

  // d dropped reads, core latency lat (>T means no done), w cycles of output backpressure
  task automatic run_block(input int d, input int lat, input int w, input bit kdrop);
    bit m;
    m = 1'($urandom_range(0, 1));
    mode_in = m;
    key_ready = 1'b1;
    n_rd = 0; n_start = 0; n_wr = 0; t_start = -1; t_wr = -1; t_err = -1;
    drop_left = d; lat_cur = lat; w_out = w; fifo_words = 4;
    in_fifo_full = 1'b1; in_fifo_empty = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (n_rd > 0) begin
        mode_in = 1'($urandom_range(0, 1));
        if (kdrop) key_ready = 1'b0;
      end
      if (lat <= T) clear_err = 1'($urandom_range(0, 1));
      if (t_wr >= 0 || t_err >= 0) break;
    end
    clear_err = 1'b0;
    chk("block_done", 32'(t_wr >= 0 || t_err >= 0), 1);
    if (lat <= T) begin
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      chk("wr_latency", t_wr - t_start, lat + 2 + w);
      chk("blk_count", 32'(blk_count), exp_cnt);
      chk("aes_mode", 32'(aes_mode), 32'(m));
      chk("busy_after_wr", 32'(busy), 0);
      chk("err_clear", 32'(err), 0);
      repeat (2) tick();
      chk("wr_pulses", n_wr, 1);
    end else begin
      chk("err_latency", t_err - t_start, T + 1);
      chk("err_set", 32'(err), 1);
      chk("busy_in_err", 32'(busy), 0);
      repeat (3) tick();
      chk("err_sticky", 32'(err), 1);
      chk("no_write", n_wr, 0);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("err_cleared", 32'(err), 0);
      chk("busy_idle", 32'(busy), 0);
    end
    chk("rd_cycles", n_rd, d + 2);
    chk("start_pulses", n_start, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_outs", 32'({in_read_en, aes_start, aes_mode, out_write_en, busy, err}), 0);
    chk("rst_cnt", 32'(blk_count), 0);
    n_rst = 1'b1;
    repeat (2) tick();
    chk("idle_busy", 32'(busy), 0);

    run_block(0, 10, 0, 1'b0);
    run_block(3, 5, 0, 1'b0);
    run_block(0, T + 1, 0, 1'b0);
    run_block(0, 4, 0, 1'b1);
    run_block(0, 3, 20, 1'b0);
    run_block(0, T, 0, 1'b0);
    run_block(0, 1, 0, 1'b0);
    for (int b = 0; b < 12; b++)
      run_block($urandom_range(0, 3), $urandom_range(1, T + 3), $urandom_range(0, 5),
                1'($urandom_range(0, 1)));

    lat_cur = 100; drop_left = 0; w_out = 0; fifo_words = 4;
    n_rd = 0; n_start = 0; n_wr = 0; t_start = -1; t_wr = -1; t_err = -1;
    in_fifo_full = 1'b1; in_fifo_empty = 1'b0; key_ready = 1'b1;
    for (int i = 0; i < 50 && t_start < 0; i++) tick();
    repeat (3) tick();
    chk("busy_wait_core", 32'(busy), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_outs", 32'({in_read_en, aes_start, aes_mode, out_write_en, busy, err}), 0);
    chk("async_rst_cnt", 32'(blk_count), 0);
    exp_cnt = 0; done_at = -1000; fifo_words = 0;
    in_fifo_full = 1'b0; in_fifo_empty = 1'b1;
    tick();
    n_rst = 1'b1;
    n_rd = 0; n_start = 0;
    repeat (6) tick();
    chk("post_rst_no_fetch", n_rd + n_start, 0);
    chk("post_rst_busy", 32'(busy), 0);

    run_block(1, 2, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
